// File: rtl/pipe_register_if.sv
// Handshake bundle for the elastic pipeline register.
// slave is the pipeline's view; master is the producer/consumer view.
interface pipe_register_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/pipe_register.sv
// Elastic pipeline register: DEPTH valid/ready stages with bubble
// collapse, synchronous flush and occupancy reporting.
module pipe_register #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    pipe_register_if.slave  bus,
    output logic [CW-1:0]   occupancy
);
    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0]            valid_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_d;
    logic [DEPTH-1:0][WIDTH-1:0] src;
    logic [DEPTH-1:0]            up;
    logic [DEPTH:0]              rdy;

    // A stage can take a word if empty or if its own word moves on.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = bus.out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = !valid_q[k] || rdy[k+1];
        end
    end

    always_comb begin
        up     = '0;
        src    = '0;
        up[0]  = bus.in_valid && !flush;
        src[0] = bus.in_data;
        for (int k = 1; k < DEPTH; k++) begin
            up[k]  = valid_q[k-1];
            src[k] = data_q[k-1];
        end
    end

    // Data only loads on a real word, never on a bubble or flush.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (rdy[k]) begin
                valid_d[k] = up[k];
                if (up[k] && !flush) begin
                    data_d[k] = src[k];
                end
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + CW'(valid_q[k]);
        end
    end

    assign bus.in_ready  = rdy[0] && !flush;
    assign bus.out_valid = valid_q[DEPTH-1];
    assign bus.out_data  = data_q[DEPTH-1];
endmodule

// File: tb/tb_pipe_register.sv
// Bench for pipe_register: a position-queue model checked every
// cycle, directed scenarios with literal expectations, random traffic.
module tb_pipe_register;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic [CW-1:0] occ;

    pipe_register_if #(.WIDTH(W)) bus ();

    pipe_register #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .bus      (bus.slave),
        .occupancy(occ)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each word in flight has a stage position; positions are
    // strictly increasing toward the head and limited by the word ahead.
    int         mpos[$];
    logic [7:0] mdat[$];
    int         np[$];
    logic [7:0] emitted[$];
    bit         ev;
    bit         pop;
    bit         ir;
    int         prev;
    int         p;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            mpos.delete();
            mdat.delete();
        end else begin
            ev   = mpos.size() > 0 && mpos[0] == D - 1;
            pop  = ev && bus.out_ready;
            prev = D;
            np.delete();
            for (int i = (pop ? 1 : 0); i < mpos.size(); i++) begin
                p = mpos[i] + 1;
                if (p > D - 1) p = D - 1;
                if (p > prev - 1) p = prev - 1;
                np.push_back(p);
                prev = p;
            end
            ir = !flush && (np.size() == 0 || np[np.size()-1] >= 1);
            chk("out_valid", bus.out_valid, ev);
            if (ev) chk("out_data", bus.out_data, mdat[0]);
            chk("occupancy", occ, mpos.size());
            chk("in_ready", bus.in_ready, ir);
            if (bus.out_valid && bus.out_ready)
                emitted.push_back(bus.out_data);
            if (flush) begin
                mpos.delete();
                mdat.delete();
            end else begin
                if (pop) void'(mdat.pop_front());
                mpos = np;
                if (bus.in_valid && ir) begin
                    mpos.push_back(0);
                    mdat.push_back(bus.in_data);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer up to n words base, base+1, ... over the given cycles.
    task automatic fill(input logic [7:0] base, input int n,
                        input int cycles, output int acc);
        bit took;
        acc = 0;
        for (int c = 0; c < cycles; c++) begin
            bus.in_valid = (acc < n);
            bus.in_data  = base + 8'(acc);
            #3;
            took = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (took) acc++;
        end
        bus.in_valid = 1'b0;
    endtask

    int acc;
    int mark;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_occ", occ, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        cyc();
        reset = 1'b0;

        // latency and throughput
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h11;
        cyc();
        bus.in_data = 8'h22;
        cyc();
        bus.in_data = 8'h33;
        cyc();
        bus.in_valid = 1'b0;
        chk("lat_no_early", bus.out_valid, 0);
        chk("lat_occ_peak", occ, 3);
        cyc();
        chk("lat_v1", bus.out_valid, 1);
        chk("lat_d1", bus.out_data, 8'h11);
        cyc();
        chk("lat_d2", bus.out_data, 8'h22);
        cyc();
        chk("lat_d3", bus.out_data, 8'h33);
        cyc();
        chk("lat_empty", bus.out_valid, 0);

        // backpressure fill then drain
        bus.out_ready = 1'b0;
        mark = emitted.size();
        fill(8'hA0, 6, 8, acc);
        chk("bp_accepts", acc, 4);
        chk("bp_occ", occ, 4);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_head", bus.out_data, 8'hA0);
        bus.out_ready = 1'b1;
        fill(8'hA4, 2, 4, acc);
        chk("bp_accepts2", acc, 2);
        repeat (8) cyc();
        chk("bp_count", emitted.size() - mark, 6);
        for (int i = 0; i < 6 && mark + i < emitted.size(); i++)
            chk("bp_order", emitted[mark+i], 8'hA0 + 8'(i));

        // full with simultaneous accept and emit
        bus.out_ready = 1'b0;
        fill(8'hB0, 4, 5, acc);
        chk("full_fill", acc, 4);
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h5C;
        bus.out_ready = 1'b1;
        #3;
        chk("full_in_ready", bus.in_ready, 1);
        cyc();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("full_occ", occ, 4);
        chk("full_emit", emitted[emitted.size()-1], 8'hB0);
        mark = emitted.size();
        bus.out_ready = 1'b1;
        repeat (8) cyc();
        chk("full_count", emitted.size() - mark, 4);
        if (emitted.size() - mark == 4) begin
            chk("full_o1", emitted[mark], 8'hB1);
            chk("full_o4", emitted[mark+3], 8'h5C);
        end

        // bubble collapse
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h01;
        cyc();
        bus.in_valid = 1'b0;
        repeat (2) cyc();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h02;
        cyc();
        bus.in_valid = 1'b0;
        repeat (4) cyc();
        chk("bub_occ", occ, 2);
        chk("bub_head", bus.out_data, 8'h01);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("bub_adj_v", bus.out_valid, 1);
        chk("bub_adj_d", bus.out_data, 8'h02);
        bus.out_ready = 1'b1;
        cyc();
        chk("bub_empty", occ, 0);

        // flush
        bus.out_ready = 1'b0;
        fill(8'hC0, 3, 3, acc);
        chk("fl_occ3", occ, 3);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        #3;
        chk("fl_in_ready", bus.in_ready, 0);
        cyc();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_occ0", occ, 0);
        chk("fl_out_valid", bus.out_valid, 0);
        mark = emitted.size();
        bus.out_ready = 1'b1;
        repeat (6) cyc();
        chk("fl_nothing", emitted.size() - mark, 0);

        // async reset mid-stream
        bus.out_ready = 1'b0;
        fill(8'hD0, 2, 2, acc);
        chk("ar_occ2", occ, 2);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_out_valid", bus.out_valid, 0);
        chk("ar_out_data", bus.out_data, 0);
        chk("ar_occ", occ, 0);
        chk("ar_in_ready", bus.in_ready, 1);
        reset = 1'b0;
        cyc();
        bus.out_ready = 1'b1;
        mark = emitted.size();
        fill(8'h77, 1, 1, acc);
        repeat (5) cyc();
        chk("ar_resume_n", emitted.size() - mark, 1);
        if (emitted.size() > mark)
            chk("ar_resume_d", emitted[mark], 8'h77);

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            bus.in_valid  = $urandom_range(0, 3) != 0;
            bus.in_data   = 8'($urandom);
            bus.out_ready = (i % 200 < 100) ?
                            ($urandom_range(0, 3) == 0) :
                            ($urandom_range(0, 3) != 0);
            flush = $urandom_range(0, 40) == 0;
            cyc();
        end
        bus.in_valid  = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) cyc();
        chk("final_empty", occ, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_register.md
Name: pipe_register

Overview:
- Parametrised elastic pipeline register: a chain of DEPTH register stages, each WIDTH bits wide.
- Every stage carries a valid/ready handshake and can be cleared with a synchronous flush.
- Successor to the plain N-bit register: adds depth, flow control, bubble collapsing and occupancy reporting.
- Inserted between a producer and a consumer to retime long paths without losing or duplicating data under backpressure.

Parameters:
- WIDTH, 8: data width in bits, must be >= 1.
- DEPTH, 4: number of register stages, must be >= 1.
- CW, $clog2(DEPTH+1): occupancy width. Derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valid bits.
- in_valid  input  1  producer presents in_data.
- in_ready  output  1  pipeline accepts in_data this cycle.
- in_data  input  WIDTH  producer data.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  consumer data.
- occupancy  output  CW  number of stages currently holding a valid word.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- State: per stage k (0 = input side, DEPTH-1 = output side), valid_k (1 bit) and data_k (WIDTH bits).
- Reset (asserted at any time, including mid-transfer): all valid_k=0 and all data_k=0 immediately.
  - Outputs while reset is asserted: out_valid=0, out_data=0, occupancy=0, in_ready=1 (valid bits are clear, flush=0).
  - No transfer completes while reset is asserted.
- Ready chain (combinational, backward):
  - ready_DEPTH = out_ready.
  - ready_k = !valid_k || ready_{k+1}.
  - in_ready = ready_0 && !flush.
- Upstream valid: up_0 = in_valid && !flush; up_k = valid_{k-1} for k >= 1.
- On each rising edge with flush=0 and reset=0:
  - if ready_k: valid_k <= up_k, and data_k <= data_{k-1} (in_data for k=0) only when up_k=1.
  - if !ready_k: stage holds.
  - Data registers never load on a bubble.
- Handshakes:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - out_valid = valid_{DEPTH-1}; out_data = data_{DEPTH-1}.
  - out_valid/out_data never depend combinationally on inputs.
  - Once out_valid=1, out_data is stable until an output transfer or flush.
- Latency: word accepted on edge t into an empty pipe appears with out_valid=1 after edge t+DEPTH-1, i.e. DEPTH cycles input-to-output.
- Throughput: one word per cycle while out_ready=1 and in_valid=1.
- Bubble collapse: when out_ready=0, upstream words advance into empty stages.
  - in_ready stays 1 until all DEPTH stages are valid.
- Capacity: exactly DEPTH words.
  - Full (occupancy=DEPTH) with out_ready=0: in_ready=0.
  - Full with out_ready=1: in_ready=1, simultaneous accept and emit, occupancy unchanged.
- Ordering: strict FIFO; no word is lost or duplicated.
- flush=1:
  - Combinationally: in_ready=0 and input is ignored.
  - On the edge: all valid_k <= 0; data_k hold their values.
  - A word with out_valid && out_ready during the flush cycle counts as consumed.
  - The pipe is empty the cycle after flush.
  - flush while empty: no effect.
- occupancy: popcount of valid_0..valid_{DEPTH-1}, registered-state based.
  - Range 0..DEPTH.
  - Changes by -1, 0 or +1 per cycle, except on flush or reset (to 0).
- Timing note: the ready path is combinational through DEPTH stages. This is accepted by design; no skid buffers.

Test Plan:
- Latency and throughput (WIDTH=8, DEPTH=4), reset then out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_valid first high 4 cycles after 0x11 accepted; 0x11,0x22,0x33 on consecutive cycles; occupancy peaks at 3.
- Backpressure fill: out_ready=0, push 0xA0..0xA5 continuously -> in_ready=0 after 4 accepts (0xA0..0xA3); occupancy=4; out_data=0xA0 stable. Then out_ready=1 -> 0xA0,0xA1,0xA2,0xA3 then 0xA4,0xA5 in order, none lost or duplicated.
- Full plus simultaneous accept and emit: pipe full, in_valid=1 with 0x5C, out_ready=1 for one cycle -> in_ready=1, head word emitted, 0x5C enters, occupancy stays 4.
- Bubble collapse: push 0x01, idle 2 cycles, push 0x02, with out_ready=0 -> both words adjacent at stages 3 and 2 after settling; occupancy=2; output order 0x01 then 0x02.
- Flush: occupancy=3, assert flush for 1 cycle with in_valid=1 (0xEE) -> in_ready=0 that cycle; next cycle occupancy=0, out_valid=0; 0xEE never emitted.
- Async reset mid-stream: reset pulsed between clock edges while occupancy=2 -> out_valid=0, out_data=0x00, occupancy=0 immediately, before the next edge; normal operation resumes after release.
